ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
Execute stage plus EX/MEM pipeline register. It consumes the ID/EX buffer outputs, computes the ALU result, resolves branch and jump, and registers the results for the memory stage. The valid/ready handshake on both sides lets downstream stalls and the multi-cycle MUL back-pressure the ID/EX buffer. Flush squashes the in-flight entry.

Parameters:
DATA_W, 32, datapath width (pc, rs, rt, x, result)
RD_W, 6, destination register index width
MUL_CYCLES, 32, iterations of the sequential multiplier (must equal DATA_W)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ID/EX entry present
in_ready  out  1  stage accepts the entry this cycle
in_ctrl_regwrt, in_ctrl_memtoreg, in_ctrl_memrd, in_ctrl_memwrt  in  1 each  pass-through control
in_ctrl_branch, in_ctrl_btype, in_ctrl_jump, in_ctrl_alusrc  in  1 each  EX control
in_ctrl_aluop  in  3  ALU operation
in_pc, in_rs, in_rt, in_x  in  DATA_W each  operands (x = immediate/target)
in_rd  in  RD_W  destination index
flush  in  1  squash the registered entry and abort MUL
out_ready  in  1  MEM stage accepts the entry
out_valid  out  1  registered entry present
out_result, out_store_data  out  DATA_W each  ALU result; rt for stores
out_rd  out  RD_W  destination
out_ctrl_regwrt, out_ctrl_memtoreg, out_ctrl_memrd, out_ctrl_memwrt  out  1 each  registered control
out_zero, out_neg  out  1 each  result==0; result[DATA_W-1]
out_redirect  out  1  out_valid and branch/jump taken
out_target  out  DATA_W  redirect address

Behaviour:
- Reset (async, rst_n low): state=IDLE, mul counter=0, every out_* register=0, out_valid=0, out_redirect=0. in_ready=0 while rst_n is low.
- Operand B = in_ctrl_alusrc ? in_x : in_rt. All arithmetic wraps mod 2^DATA_W; no overflow flag.
- aluop: 000 ADD A+B; 001 SUB A-B; 010 NEG 0-A; 011 INC A+1; 100 AND; 101 OR; 110 PASSB B; 111 MUL (low DATA_W bits of A*B).
- Branch taken = in_ctrl_jump | (in_ctrl_branch & (in_ctrl_btype ? in_rs[DATA_W-1] : in_rs==0)). Target = in_x. Both are captured with the entry.
- in_ready = (state==IDLE) & (!out_valid | out_ready) & !flush. Accept = in_valid & in_ready.
- States:
  - IDLE: on accepting a non-MUL op, load the output register at that edge and set out_valid=1 (latency 1). On accepting MUL, latch operands and control, clear out_valid, go to MUL_BUSY with count=0.
  - MUL_BUSY: perform one shift-add iteration per cycle. When count==MUL_CYCLES-1, load the result into the output register, set out_valid=1 and return to IDLE. Out_valid therefore appears MUL_CYCLES edges after acceptance. in_ready stays 0 throughout.
- Output hold: while out_valid & !out_ready, every out_* signal is stable.
- If out_valid & out_ready and there is no new accept, out_valid clears next edge.
- flush: out_valid=0 and out_redirect=0 next edge. MUL_BUSY aborts to IDLE. A simultaneous in_valid is not accepted.
- out_redirect = out_valid & taken_q, so it is never asserted without out_valid.
- Reset mid-MUL discards the partial product.

Optional Feature:
EX_MUL_EN.
- Defined: aluop 111 runs the sequential multiplier described above.
- Undefined: no MUL_BUSY state and no multiplier logic. aluop 111 completes in 1 cycle with result 0, and in_ready never drops for MUL.

Decomposition:
- Shared package ex_pkg: aluop constants (ALU_ADD..ALU_MUL), state enum {IDLE, MUL_BUSY}, DATA_W/RD_W defaults.
- One sub-module ex_mul_seq (start, a, b, busy, done, product; MUL_CYCLES iterations, async active-low reset), instantiated only under EX_MUL_EN.

Test Plan:
- ADD: rs=5, rt=7, alusrc=0, aluop=000, out_ready=1 -> next cycle out_valid=1, out_result=12, out_zero=0.
- SUB wrap: rs=0, x=1, alusrc=1, aluop=001 -> out_result=0xFFFFFFFF, out_neg=1; NEG of 0 -> 0, out_zero=1.
- Branch: branch=1, btype=0, rs=0, x=0x40 -> out_redirect=1, out_target=0x40; with rs=3 -> out_redirect=0. Jump=1 -> redirect regardless of rs.
- Back-pressure: hold out_ready=0 for 3 cycles -> in_ready=0 and out_* unchanged; release -> entry drains, next entry accepted same edge.
- MUL (EX_MUL_EN): rs=3, rt=0xFFFFFFFF -> in_ready=0 for 32 cycles, then out_result=0xFFFFFFFD. Without the macro -> 1 cycle, result 0.
- Flush during MUL at cycle 10 with in_valid=1 -> out_valid stays 0, input not accepted; next cycle in_ready=1. Assert rst_n=0 mid-MUL -> all outputs 0 immediately.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, stage states and default widths.
package ex_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RD_W_DEF   = 6;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_NEG   = 3'b010;
  localparam logic [2:0] ALU_INC   = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_PASSB = 3'b110;
  localparam logic [2:0] ALU_MUL   = 3'b111;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/ex_mem_stage_mul.sv
// Sequential shift-add multiplier: one partial-product step per cycle, CYCLES steps,
// product is the low W bits. Only instantiated when EX_MUL_EN is defined.
module ex_mul_seq #(
  parameter int W      = 32,
  parameter int CYCLES = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES - 1);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [W-1:0]     acc_next_s;

  // The final step's sum is exposed directly so the stage can load it on the last edge.
  assign acc_next_s = acc_q + (mplier_q[0] ? mcand_q : {W{1'b0}});
  assign done       = busy_q & (cnt_q == LAST_CNT);
  assign busy       = busy_q;
  assign product    = acc_next_s;

  // Next-state for the iteration registers.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = {CNT_W{1'b0}};
    end else if (start) begin
      busy_d   = 1'b1;
      cnt_d    = {CNT_W{1'b0}};
      acc_d    = {W{1'b0}};
      mcand_d  = a;
      mplier_d = b;
    end else if (busy_q) begin
      acc_d    = acc_next_s;
      mcand_d  = {mcand_q[W-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[W-1:1]};
      if (cnt_q == LAST_CNT) begin
        busy_d = 1'b0;
        cnt_d  = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Iteration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {W{1'b0}};
      mcand_q  <= {W{1'b0}};
      mplier_q <= {W{1'b0}};
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage plus EX/MEM register with valid/ready on both sides.
// Define EX_MUL_EN to make aluop 111 run the sequential multiplier; otherwise it yields 0 in one cycle.
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_W       = RD_W_DEF,
  parameter int MUL_CYCLES = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_ctrl_regwrt,
  input  logic              in_ctrl_memtoreg,
  input  logic              in_ctrl_memrd,
  input  logic              in_ctrl_memwrt,
  input  logic              in_ctrl_branch,
  input  logic              in_ctrl_btype,
  input  logic              in_ctrl_jump,
  input  logic              in_ctrl_alusrc,
  input  logic [2:0]        in_ctrl_aluop,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_rs,
  input  logic [DATA_W-1:0] in_rt,
  input  logic [DATA_W-1:0] in_x,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_ctrl_regwrt,
  output logic              out_ctrl_memtoreg,
  output logic              out_ctrl_memrd,
  output logic              out_ctrl_memwrt,
  output logic              out_zero,
  output logic              out_neg,
  output logic              out_redirect,
  output logic [DATA_W-1:0] out_target
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              regwrt_q, regwrt_d, memtoreg_q, memtoreg_d;
  logic              memrd_q, memrd_d, memwrt_q, memwrt_d;
  logic              zero_q, zero_d, neg_q, neg_d, taken_q, taken_d;

  logic [DATA_W-1:0] op_b_s, alu_s, mul_prod_s;
  logic              taken_s, accept_s, is_mul_s, mul_busy_s, mul_done_s;

  assign op_b_s   = in_ctrl_alusrc ? in_x : in_rt;
  assign taken_s  = in_ctrl_jump |
                    (in_ctrl_branch & (in_ctrl_btype ? in_rs[DATA_W-1] : (in_rs == {DATA_W{1'b0}})));
  assign in_ready = rst_n & ~mul_busy_s & (~valid_q | out_ready) & ~flush;
  assign accept_s = in_valid & in_ready;

`ifdef EX_MUL_EN
  state_e state_q, state_d;
  logic   mul_seq_busy_s;

  assign is_mul_s   = (in_ctrl_aluop == ALU_MUL);
  assign mul_busy_s = (state_q == MUL_BUSY) | mul_seq_busy_s;

  ex_mul_seq #(
    .W      (DATA_W),
    .CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept_s & is_mul_s),
    .abort   (flush),
    .a       (in_rs),
    .b       (op_b_s),
    .busy    (mul_seq_busy_s),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  // Stage FSM next state; flush aborts a running multiply.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else if (mul_done_s) begin
      state_d = IDLE;
    end else if (accept_s && is_mul_s) begin
      state_d = MUL_BUSY;
    end else begin
      state_d = state_q;
    end
  end

  // Stage FSM register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end
`else
  assign is_mul_s   = 1'b0;
  assign mul_busy_s = 1'b0;
  assign mul_done_s = 1'b0;
  assign mul_prod_s = {DATA_W{1'b0}};
`endif

  // Single-cycle ALU; MUL is produced by the multiplier (or is 0 without it).
  always_comb begin
    alu_s = {DATA_W{1'b0}};
    case (in_ctrl_aluop)
      ALU_ADD:   alu_s = in_rs + op_b_s;
      ALU_SUB:   alu_s = in_rs - op_b_s;
      ALU_NEG:   alu_s = {DATA_W{1'b0}} - in_rs;
      ALU_INC:   alu_s = in_rs + {{(DATA_W-1){1'b0}}, 1'b1};
      ALU_AND:   alu_s = in_rs & op_b_s;
      ALU_OR:    alu_s = in_rs | op_b_s;
      ALU_PASSB: alu_s = op_b_s;
      default:   alu_s = {DATA_W{1'b0}};
    endcase
  end

  // Output register next state: flush > multiply completion > accept > drain > hold.
  always_comb begin
    valid_d    = valid_q;
    result_d   = result_q;
    store_d    = store_q;
    target_d   = target_q;
    rd_d       = rd_q;
    regwrt_d   = regwrt_q;
    memtoreg_d = memtoreg_q;
    memrd_d    = memrd_q;
    memwrt_d   = memwrt_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    taken_d    = taken_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (mul_done_s) begin
      result_d = mul_prod_s;
      zero_d   = (mul_prod_s == {DATA_W{1'b0}});
      neg_d    = mul_prod_s[DATA_W-1];
      valid_d  = 1'b1;
    end else if (accept_s) begin
      // Control is captured at accept even for MUL; it stays invisible until valid rises.
      store_d    = in_rt;
      target_d   = in_x;
      rd_d       = in_rd;
      regwrt_d   = in_ctrl_regwrt;
      memtoreg_d = in_ctrl_memtoreg;
      memrd_d    = in_ctrl_memrd;
      memwrt_d   = in_ctrl_memwrt;
      taken_d    = taken_s;
      if (is_mul_s) begin
        valid_d = 1'b0;
      end else begin
        result_d = alu_s;
        zero_d   = (alu_s == {DATA_W{1'b0}});
        neg_d    = alu_s[DATA_W-1];
        valid_d  = 1'b1;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // EX/MEM register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      result_q   <= {DATA_W{1'b0}};
      store_q    <= {DATA_W{1'b0}};
      target_q   <= {DATA_W{1'b0}};
      rd_q       <= {RD_W{1'b0}};
      regwrt_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      memrd_q    <= 1'b0;
      memwrt_q   <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      taken_q    <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      result_q   <= result_d;
      store_q    <= store_d;
      target_q   <= target_d;
      rd_q       <= rd_d;
      regwrt_q   <= regwrt_d;
      memtoreg_q <= memtoreg_d;
      memrd_q    <= memrd_d;
      memwrt_q   <= memwrt_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      taken_q    <= taken_d;
    end
  end

  assign out_valid         = valid_q;
  assign out_result        = result_q;
  assign out_store_data    = store_q;
  assign out_target        = target_q;
  assign out_rd            = rd_q;
  assign out_ctrl_regwrt   = regwrt_q;
  assign out_ctrl_memtoreg = memtoreg_q;
  assign out_ctrl_memrd    = memrd_q;
  assign out_ctrl_memwrt   = memwrt_q;
  assign out_zero          = zero_q;
  assign out_neg           = neg_q;
  assign out_redirect      = valid_q & taken_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed plus randomized bench for ex_mem_stage against a plain-arithmetic reference model.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic        in_ctrl_regwrt, in_ctrl_memtoreg, in_ctrl_memrd, in_ctrl_memwrt;
  logic        in_ctrl_branch, in_ctrl_btype, in_ctrl_jump, in_ctrl_alusrc;
  logic [2:0]  in_ctrl_aluop;
  logic [31:0] in_pc, in_rs, in_rt, in_x;
  logic [5:0]  in_rd;
  logic        flush, out_ready, out_valid;
  logic [31:0] out_result, out_store_data, out_target;
  logic [5:0]  out_rd;
  logic        out_ctrl_regwrt, out_ctrl_memtoreg, out_ctrl_memrd, out_ctrl_memwrt;
  logic        out_zero, out_neg, out_redirect;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic        alusrc, branch, btype, jump, regwrt, memtoreg, memrd, memwrt;
    logic [31:0] pc, rs, rt, x;
    logic [5:0]  rd;
  } ent_t;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl_regwrt(in_ctrl_regwrt), .in_ctrl_memtoreg(in_ctrl_memtoreg),
    .in_ctrl_memrd(in_ctrl_memrd), .in_ctrl_memwrt(in_ctrl_memwrt),
    .in_ctrl_branch(in_ctrl_branch), .in_ctrl_btype(in_ctrl_btype),
    .in_ctrl_jump(in_ctrl_jump), .in_ctrl_alusrc(in_ctrl_alusrc),
    .in_ctrl_aluop(in_ctrl_aluop), .in_pc(in_pc), .in_rs(in_rs), .in_rt(in_rt),
    .in_x(in_x), .in_rd(in_rd), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_result(out_result), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_ctrl_regwrt(out_ctrl_regwrt), .out_ctrl_memtoreg(out_ctrl_memtoreg),
    .out_ctrl_memrd(out_ctrl_memrd), .out_ctrl_memwrt(out_ctrl_memwrt),
    .out_zero(out_zero), .out_neg(out_neg), .out_redirect(out_redirect),
    .out_target(out_target)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic mul_multicycle(input ent_t e);
`ifdef EX_MUL_EN
    return e.op == 3'b111;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: the spec's arithmetic rules, 32-bit wrap by declaration width.
  function automatic logic [31:0] model_result(input ent_t e);
    logic [31:0] b;
    b = e.alusrc ? e.x : e.rt;
    case (e.op)
      3'd0: return e.rs + b;
      3'd1: return e.rs - b;
      3'd2: return 32'd0 - e.rs;
      3'd3: return e.rs + 32'd1;
      3'd4: return e.rs & b;
      3'd5: return e.rs | b;
      3'd6: return b;
`ifdef EX_MUL_EN
      3'd7: return e.rs * b;
`else
      3'd7: return 32'd0;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_taken(input ent_t e);
    return e.jump || (e.branch && (e.btype ? e.rs[31] : (e.rs == 32'd0)));
  endfunction

  function automatic ent_t mk(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                              input logic [31:0] x, input logic alusrc);
    ent_t e;
    e = '{op: op, alusrc: alusrc, branch: 1'b0, btype: 1'b0, jump: 1'b0, regwrt: 1'b1,
          memtoreg: 1'b0, memrd: 1'b0, memwrt: 1'b0, pc: 32'h100, rs: rs, rt: rt, x: x, rd: 6'd9};
    return e;
  endfunction

  task automatic drive(input ent_t e);
    in_ctrl_aluop = e.op; in_ctrl_alusrc = e.alusrc; in_ctrl_branch = e.branch;
    in_ctrl_btype = e.btype; in_ctrl_jump = e.jump; in_ctrl_regwrt = e.regwrt;
    in_ctrl_memtoreg = e.memtoreg; in_ctrl_memrd = e.memrd; in_ctrl_memwrt = e.memwrt;
    in_pc = e.pc; in_rs = e.rs; in_rt = e.rt; in_x = e.x; in_rd = e.rd;
  endtask

  task automatic check_out(input string tag, input ent_t e);
    logic [31:0] r;
    r = model_result(e);
    chk({tag, ":valid"}, out_valid, 32'd1);
    chk({tag, ":result"}, out_result, r);
    chk({tag, ":zero"}, out_zero, (r == 32'd0) ? 32'd1 : 32'd0);
    chk({tag, ":neg"}, out_neg, r[31]);
    chk({tag, ":store"}, out_store_data, e.rt);
    chk({tag, ":rd"}, out_rd, e.rd);
    chk({tag, ":ctrl"}, {out_ctrl_regwrt, out_ctrl_memtoreg, out_ctrl_memrd, out_ctrl_memwrt},
        {e.regwrt, e.memtoreg, e.memrd, e.memwrt});
    chk({tag, ":redirect"}, out_redirect, model_taken(e));
    chk({tag, ":target"}, out_target, e.x);
  endtask

  // Present e, wait (bounded) for acceptance, check the result appears at the right latency, then drain.
  task automatic run(input string tag, input ent_t e);
    int waited;
    drive(e);
    in_valid = 1'b1;
    out_ready = 1'b1;
    waited = 0;
    while (!in_ready && waited < 100) begin
      tick();
      waited++;
    end
    chk({tag, ":accept_wait"}, (waited < 100) ? 32'd1 : 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    if (mul_multicycle(e)) begin
      int early;
      int rdy;
      early = 0;
      rdy = 0;
      chk({tag, ":mul_start_valid"}, out_valid, 32'd0);
      for (int i = 1; i < 32; i++) begin
        if (out_valid) early++;
        if (in_ready) rdy++;
        tick();
      end
      chk({tag, ":mul_early_valid"}, early, 32'd0);
      chk({tag, ":mul_ready_low"}, rdy, 32'd0);
    end
    check_out(tag, e);
    tick();
    chk({tag, ":drain"}, out_valid, 32'd0);
  endtask

  initial begin
    ent_t ea, eb;
    int   seen;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(mk(3'd0, 32'd0, 32'd0, 32'd0, 1'b0));

    #12;
    chk("reset:valid", out_valid, 32'd0);
    chk("reset:in_ready", in_ready, 32'd0);
    chk("reset:result", out_result, 32'd0);
    chk("reset:redirect", out_redirect, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("post_reset:in_ready", in_ready, 32'd1);

    run("add", mk(3'd0, 32'd5, 32'd7, 32'd0, 1'b0));
    run("sub_wrap", mk(3'd1, 32'd0, 32'd0, 32'd1, 1'b1));
    run("neg_zero", mk(3'd2, 32'd0, 32'd3, 32'd0, 1'b0));
    run("inc_wrap", mk(3'd3, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0));

    ea = mk(3'd6, 32'd0, 32'd0, 32'h40, 1'b1); ea.branch = 1'b1;
    run("beq_taken", ea);
    ea.rs = 32'd3;
    run("beq_not", ea);
    ea.jump = 1'b1;
    run("jump", ea);
    ea = mk(3'd0, 32'h8000_0000, 32'd1, 32'h80, 1'b0); ea.branch = 1'b1; ea.btype = 1'b1;
    run("bneg_taken", ea);

    // Back-pressure: A stalls in the register for 3 cycles while B waits.
    ea = mk(3'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 1'b0); ea.memwrt = 1'b1; ea.rd = 6'd17;
    eb = mk(3'd5, 32'h0000_00F0, 32'd0, 32'h0000_0F0F, 1'b1); eb.rd = 6'd33;
    drive(ea); in_valid = 1'b1; out_ready = 1'b0;
    #1 chk("bp:a_ready", in_ready, 32'd1);
    tick();
    drive(eb);
    #1 chk("bp:b_blocked", in_ready, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("bp_hold", ea);
      chk("bp:ready_low", in_ready, 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp:ready_release", in_ready, 32'd1);
    tick();
    in_valid = 1'b0;
    check_out("bp_b", eb);
    tick();
    chk("bp:drain", out_valid, 32'd0);

    run("mul", mk(3'd7, 32'd3, 32'hFFFF_FFFF, 32'd0, 1'b0));

    // Flush of a held entry with a competing in_valid.
    ea = mk(3'd0, 32'd1, 32'd2, 32'h44, 1'b0); ea.jump = 1'b1;
    drive(ea); in_valid = 1'b1; out_ready = 1'b0;
    tick();
    chk("flush:held_redirect", out_redirect, 32'd1);
    drive(mk(3'd0, 32'd9, 32'd9, 32'd0, 1'b0)); flush = 1'b1;
    #1 chk("flush:in_ready", in_ready, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush:valid", out_valid, 32'd0);
    chk("flush:redirect", out_redirect, 32'd0);
    out_ready = 1'b1;

`ifdef EX_MUL_EN
    // Flush at cycle 10 of a multiply, new entry offered meanwhile.
    drive(mk(3'd7, 32'd7, 32'd6, 32'd0, 1'b0)); in_valid = 1'b1;
    #1 chk("mflush:accept", in_ready, 32'd1);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    drive(mk(3'd0, 32'd1, 32'd1, 32'd0, 1'b0)); in_valid = 1'b1; flush = 1'b1;
    #1 chk("mflush:in_ready", in_ready, 32'd0);
    tick();
    flush = 1'b0;
    chk("mflush:valid", out_valid, 32'd0);
    #1 chk("mflush:ready_after", in_ready, 32'd1);
    in_valid = 1'b0;
    seen = 0;
    repeat (30) begin tick(); if (out_valid) seen++; end
    chk("mflush:no_late_result", seen, 32'd0);

    // Reset in the middle of a multiply.
    drive(mk(3'd7, 32'd5, 32'd5, 32'd0, 1'b0)); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("mreset:valid", out_valid, 32'd0);
    chk("mreset:result", out_result, 32'd0);
    chk("mreset:in_ready", in_ready, 32'd0);
    chk("mreset:target", out_target, 32'd0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (35) begin tick(); if (out_valid) seen++; end
    chk("mreset:no_late_result", seen, 32'd0);
`else
    // Reset while an entry is held.
    drive(mk(3'd0, 32'd8, 32'd8, 32'h10, 1'b0)); in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("hreset:held", out_result, 32'd16);
    rst_n = 1'b0;
    #1;
    chk("hreset:valid", out_valid, 32'd0);
    chk("hreset:result", out_result, 32'd0);
    chk("hreset:in_ready", in_ready, 32'd0);
    chk("hreset:target", out_target, 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
`endif

    for (int n = 0; n < 40; n++) begin
      ent_t er;
      er = mk(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) er.rs = 32'd0;
      er.branch = 1'($urandom_range(0, 1)); er.btype = 1'($urandom_range(0, 1));
      er.jump = ($urandom_range(0, 4) == 0); er.regwrt = 1'($urandom_range(0, 1));
      er.memtoreg = 1'($urandom_range(0, 1)); er.memrd = 1'($urandom_range(0, 1));
      er.memwrt = 1'($urandom_range(0, 1)); er.rd = 6'($urandom_range(0, 63));
      run("rand", er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
